// File: rtl/axilwb_rw_arbiter.sv
// axilwb_rw_arbiter -- shares one pipelined Wishbone master between the AXI-lite read and write bridges.
// Revision 1.0

`default_nettype none

module axilwb_rw_arbiter #(
   parameter int AW           = 26,
   parameter int DW           = 32,
   parameter int LGOUT        = 4,
   parameter bit OPT_LOWPOWER = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_axi_reset_n,
   // port A: read bridge
   input  logic              i_a_cyc,
   input  logic              i_a_stb,
   input  logic              i_a_we,
   input  logic [AW-1:0]     i_a_addr,
   input  logic [DW-1:0]     i_a_data,
   input  logic [DW/8-1:0]   i_a_sel,
   output logic              o_a_stall,
   output logic              o_a_ack,
   output logic              o_a_err,
   // port B: write bridge
   input  logic              i_b_cyc,
   input  logic              i_b_stb,
   input  logic              i_b_we,
   input  logic [AW-1:0]     i_b_addr,
   input  logic [DW-1:0]     i_b_data,
   input  logic [DW/8-1:0]   i_b_sel,
   output logic              o_b_stall,
   output logic              o_b_ack,
   output logic              o_b_err,
   // shared master
   output logic              o_wb_cyc,
   output logic              o_wb_stb,
   output logic              o_wb_we,
   output logic [AW-1:0]     o_wb_addr,
   output logic [DW-1:0]     o_wb_data,
   output logic [DW/8-1:0]   o_wb_sel,
   input  logic              i_wb_ack,
   input  logic              i_wb_stall,
   input  logic              i_wb_err,
   output logic [1:0]        o_grant
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic             last_owner;        // 1 = B held the bus last
   logic [LGOUT-1:0] count;
   logic             err_lock;

   logic own_a, own_b;
   logic owner_cyc, owner_stb, owner_stall;
   logic full, wb_cyc, wb_stb;
   logic fwd_ack, fwd_err;
   logic accept, release_bus, state_change;

   // ---------------- next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (i_a_cyc && i_b_cyc)
               state_nxt = last_owner ? OWN_A : OWN_B;
            else if (i_a_cyc)
               state_nxt = OWN_A;
            else if (i_b_cyc)
               state_nxt = OWN_B;
         end
         OWN_A: begin
            if (!i_a_cyc)
               state_nxt = i_b_cyc ? OWN_B : IDLE;
         end
         OWN_B: begin
            if (!i_b_cyc)
               state_nxt = i_a_cyc ? OWN_A : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- owner-side datapath and responses
   always_comb begin
      own_a       = (state == OWN_A);
      own_b       = (state == OWN_B);
      owner_cyc   = (own_a & i_a_cyc) | (own_b & i_b_cyc);
      owner_stb   = (own_a & i_a_stb) | (own_b & i_b_stb);
      full        = &count;
      wb_cyc      = owner_cyc & ~err_lock;
      wb_stb      = wb_cyc & owner_stb & ~full;
      // an error on the same cycle as an ack swallows the ack
      fwd_err     = i_wb_err & wb_cyc;
      fwd_ack     = i_wb_ack & wb_cyc & (|count) & ~i_wb_err;
      owner_stall = i_wb_stall | full | err_lock;
      accept      = wb_stb & ~i_wb_stall;
      release_bus = (own_a | own_b) & ~owner_cyc;
      state_change = (state_nxt != state);

      o_wb_cyc  = wb_cyc;
      o_wb_stb  = wb_stb;
      o_a_stall = own_a ? owner_stall : 1'b1;
      o_b_stall = own_b ? owner_stall : 1'b1;
      o_a_ack   = own_a & fwd_ack;
      o_b_ack   = own_b & fwd_ack;
      o_a_err   = own_a & fwd_err;
      o_b_err   = own_b & fwd_err;
      o_grant   = {own_b, own_a};
   end

   // ---------------- payload mux
   always_comb begin
      o_wb_we   = own_b ? i_b_we   : i_a_we;
      o_wb_addr = own_b ? i_b_addr : i_a_addr;
      o_wb_data = own_b ? i_b_data : i_a_data;
      o_wb_sel  = own_b ? i_b_sel  : i_a_sel;
      if (OPT_LOWPOWER && !wb_stb) begin
         o_wb_we   = 1'b0;
         o_wb_addr = '0;
         o_wb_data = '0;
         o_wb_sel  = '0;
      end
   end

   // ---------------- registered state
   always_ff @(posedge i_clk) begin
      if (!i_axi_reset_n) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         count      <= '0;
         err_lock   <= 1'b0;
      end else begin
         state <= state_nxt;

         if (release_bus)
            last_owner <= own_b;

         if (state_change)
            err_lock <= 1'b0;
         else if (fwd_err)
            err_lock <= 1'b1;

         // accept and ack together leave the count unchanged
         if (state_change || fwd_err)
            count <= '0;
         else if (accept && !fwd_ack)
            count <= count + LGOUT'(1);
         else if (fwd_ack && !accept)
            count <= count - LGOUT'(1);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axilwb_rw_arbiter.sv
// Directed self-checking bench for axilwb_rw_arbiter (default build plus an OPT_LOWPOWER build).
// Revision 1.0

`timescale 1ns/1ps
`default_nettype none

module tb_axilwb_rw_arbiter;

   localparam int AW = 26;
   localparam int DW = 32;
   localparam int SW = DW/8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_data, b_data;
   logic [SW-1:0] a_sel, b_sel;
   logic          wb_ack, wb_stall, wb_err;

   logic          a_stall, a_ack, a_err, b_stall, b_ack, b_err;
   logic          wb_cyc, wb_stb, wb_we;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic [SW-1:0] wb_sel;
   logic [1:0]    grant;

   logic          lp_a_stall, lp_a_ack, lp_a_err, lp_b_stall, lp_b_ack, lp_b_err;
   logic          lp_cyc, lp_stb, lp_we;
   logic [AW-1:0] lp_addr;
   logic [DW-1:0] lp_data;
   logic [SW-1:0] lp_sel;
   logic [1:0]    lp_grant;

   int checks = 0;
   int errors = 0;
   int acc;

   always #5 clk = ~clk;

   axilwb_rw_arbiter #(.AW(AW), .DW(DW), .LGOUT(4), .OPT_LOWPOWER(1'b0)) dut (
      .i_clk(clk), .i_axi_reset_n(rst_n),
      .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
      .i_a_data(a_data), .i_a_sel(a_sel),
      .o_a_stall(a_stall), .o_a_ack(a_ack), .o_a_err(a_err),
      .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
      .i_b_data(b_data), .i_b_sel(b_sel),
      .o_b_stall(b_stall), .o_b_ack(b_ack), .o_b_err(b_err),
      .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
      .o_wb_data(wb_data), .o_wb_sel(wb_sel),
      .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err),
      .o_grant(grant)
   );

   axilwb_rw_arbiter #(.AW(AW), .DW(DW), .LGOUT(4), .OPT_LOWPOWER(1'b1)) dut_lp (
      .i_clk(clk), .i_axi_reset_n(rst_n),
      .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
      .i_a_data(a_data), .i_a_sel(a_sel),
      .o_a_stall(lp_a_stall), .o_a_ack(lp_a_ack), .o_a_err(lp_a_err),
      .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
      .i_b_data(b_data), .i_b_sel(b_sel),
      .o_b_stall(lp_b_stall), .o_b_ack(lp_b_ack), .o_b_err(lp_b_err),
      .o_wb_cyc(lp_cyc), .o_wb_stb(lp_stb), .o_wb_we(lp_we), .o_wb_addr(lp_addr),
      .o_wb_data(lp_data), .o_wb_sel(lp_sel),
      .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err),
      .o_grant(lp_grant)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // step past the next rising edge; inputs are driven after this, outputs checked #1 later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      a_cyc = 0; a_stb = 0; a_we = 0; a_addr = '0; a_data = '0; a_sel = '0;
      b_cyc = 0; b_stb = 0; b_we = 0; b_addr = '0; b_data = '0; b_sel = '0;
      wb_ack = 0; wb_stall = 0; wb_err = 0;

      // reset state
      tick(); tick(); #1;
      check("rst_grant", grant, 2'b00);
      check("rst_cyc", wb_cyc, 0);
      check("rst_stb", wb_stb, 0);
      check("rst_a_stall", a_stall, 1);
      check("rst_b_stall", b_stall, 1);
      check("rst_acks", {a_ack, b_ack, a_err, b_err}, 4'b0000);
      rst_n = 1'b1;
      tick();

      // single A request, one-cycle slave ack
      a_cyc = 1; a_stb = 1; a_addr = 26'h10; a_we = 0; a_sel = 4'hF; a_data = 32'h1234_5678;
      #1;
      check("t1_idle_grant", grant, 2'b00);
      check("t1_idle_cyc", wb_cyc, 0);
      check("t1_idle_a_stall", a_stall, 1);
      tick(); #1;
      check("t1_grant", grant, 2'b01);
      check("t1_cyc", wb_cyc, 1);
      check("t1_stb", wb_stb, 1);
      check("t1_addr", wb_addr, 26'h10);
      check("t1_sel", wb_sel, 4'hF);
      check("t1_we", wb_we, 0);
      check("t1_a_stall", a_stall, 0);
      check("t1_b_stall", b_stall, 1);
      tick();
      a_stb = 0; wb_ack = 1; #1;
      check("t1_a_ack", a_ack, 1);
      check("t1_b_quiet", {b_ack, b_err}, 2'b00);
      check("t1_stb_off", wb_stb, 0);
      tick();
      wb_ack = 0; a_cyc = 0; #1;
      check("t1_ack_once", a_ack, 0);
      check("t1_release_cyc", wb_cyc, 0);
      tick(); #1;
      check("t1_back_idle", grant, 2'b00);

      // contention straight after reset: A first, then B after a one-cycle gap
      rst_n = 0; tick(); rst_n = 1;
      a_cyc = 1; b_cyc = 1; #1;
      check("t2_idle", grant, 2'b00);
      tick(); #1;
      check("t2_grant_a", grant, 2'b01);
      check("t2_cyc_a", wb_cyc, 1);
      check("t2_b_stall", b_stall, 1);
      a_cyc = 0; #1;
      check("t2_gap", wb_cyc, 0);
      tick(); #1;
      check("t2_grant_b", grant, 2'b10);
      check("t2_cyc_b", wb_cyc, 1);

      // B bursts 20 strobes with no acks: counter saturates at 15
      b_stb = 1; b_we = 1; b_addr = 26'h155; b_data = 32'hCAFE_F00D; b_sel = 4'hC;
      #1;
      check("t3_addr", wb_addr, 26'h155);
      check("t3_data", wb_data, 32'hCAFE_F00D);
      check("t3_sel", wb_sel, 4'hC);
      check("t3_we", wb_we, 1);
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         if (wb_stb && !wb_stall) acc++;
         tick(); #1;
      end
      check("t3_accepted", acc, 15);
      check("t3_full_stall", b_stall, 1);
      check("t3_full_nostb", wb_stb, 0);
      wb_ack = 1; #1;
      check("t3_ack", b_ack, 1);
      check("t3_ack_nostb", wb_stb, 0);
      tick();
      wb_ack = 0; #1;
      check("t3_16th_stb", wb_stb, 1);
      check("t3_16th_stall", b_stall, 0);
      tick();
      b_stb = 0; b_cyc = 0; #1;
      check("t3_release", wb_cyc, 0);
      tick();
      wb_ack = 1; #1;
      check("t3_late_ack", b_ack, 0);
      check("t3_idle", grant, 2'b00);
      tick();
      wb_ack = 0;

      // A gets err and ack together while B waits
      a_cyc = 1; a_stb = 1; a_addr = 26'h22; #1;
      tick(); #1;
      check("t4_grant_a", grant, 2'b01);
      check("t4_stb", wb_stb, 1);
      tick();
      a_stb = 0; b_cyc = 1; wb_ack = 1; wb_err = 1; #1;
      check("t4_a_err", a_err, 1);
      check("t4_a_noack", a_ack, 0);
      check("t4_b_quiet", {b_ack, b_err}, 2'b00);
      tick();
      wb_ack = 0; wb_err = 0; #1;
      check("t4_lock_cyc", wb_cyc, 0);
      check("t4_lock_stall", a_stall, 1);
      check("t4_lock_grant", grant, 2'b01);
      wb_ack = 1; #1;
      check("t4_lock_ack", a_ack, 0);
      tick();
      wb_ack = 0; a_cyc = 0; #1;
      check("t4_release", wb_cyc, 0);
      tick(); #1;
      check("t4_grant_b", grant, 2'b10);
      check("t4_cyc_b", wb_cyc, 1);

      // reset with three outstanding under B
      b_stb = 1;
      acc = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (wb_stb && !wb_stall) acc++;
         tick();
      end
      b_stb = 0; #1;
      check("t5_accepted", acc, 3);
      rst_n = 0;
      tick(); #1;
      check("t5_grant", grant, 2'b00);
      check("t5_cyc", wb_cyc, 0);
      wb_ack = 1; #1;
      check("t5_late_ack_rst", b_ack, 0);
      tick();
      rst_n = 1; b_cyc = 0; #1;
      check("t5_late_ack", b_ack, 0);
      tick();
      wb_ack = 0;

      // low-power build: idle with nonzero port inputs
      a_addr = 26'h3AB; a_data = 32'hDEAD_BEEF; a_sel = 4'hF; a_we = 1;
      b_addr = 26'h2CD; b_data = 32'h5555_AAAA; b_sel = 4'h3; b_we = 1;
      #1;
      check("t6_lp_addr", lp_addr, 0);
      check("t6_lp_data", lp_data, 0);
      check("t6_lp_sel", lp_sel, 0);
      check("t6_lp_we", lp_we, 0);
      a_cyc = 1; a_stb = 1;
      tick(); #1;
      check("t6_lp_stb_addr", lp_addr, 26'h3AB);
      check("t6_lp_stb_we", lp_we, 1);
      tick();
      a_stb = 0; #1;
      check("t6_lp_nostb_data", lp_data, 0);
      a_cyc = 0;
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
